// File: rtl/simple_system_timer_mc.sv
// Multi-channel system timer for the simple-system bus.
// One shared prescaler drives NumChannels up-counters. Each counter has a
// compare value and either periodic or one-shot behaviour. The per-channel
// interrupts are maskable and are also OR-combined into a single line.
// The device occupies a 1 kB window and decodes only address bits [9:2].

module simple_system_timer_mc #(
  parameter int unsigned NumChannels    = 4,
  parameter int unsigned CounterWidth   = 32,
  parameter int unsigned PrescalerWidth = 16,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddressWidth   = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    timer_req_i,
  input  logic                    timer_we_i,
  input  logic [3:0]              timer_be_i,
  input  logic [AddressWidth-1:0] timer_addr_i,
  input  logic [DataWidth-1:0]    timer_wdata_i,
  output logic                    timer_rvalid_o,
  output logic [DataWidth-1:0]    timer_rdata_o,
  output logic                    timer_err_o,

  output logic                    timer_intr_o,
  output logic [NumChannels-1:0]  timer_chan_intr_o
);

  // Word offsets of the global registers (byte offset >> 2).
  localparam logic [7:0] WordPrescale   = 8'h00;
  localparam logic [7:0] WordIntrState  = 8'h01;
  localparam logic [7:0] WordIntrEnable = 8'h02;

  // Channel register selectors, from address bits [3:2].
  localparam logic [1:0] ChanCtrl    = 2'd0;
  localparam logic [1:0] ChanCount   = 2'd1;
  localparam logic [1:0] ChanCompare = 2'd2;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic [7:0]             word;
  logic                   sel_prescale;
  logic                   sel_intr_state;
  logic                   sel_intr_enable;
  logic                   in_chan_space;
  logic [2:0]             chan_idx;
  logic [1:0]             chan_reg;
  logic [NumChannels-1:0] chan_sel;
  logic                   dec_ok;
  logic                   wr_en;
  logic [31:0]            be_mask;

  assign word            = timer_addr_i[9:2];
  assign sel_prescale    = (word == WordPrescale);
  assign sel_intr_state  = (word == WordIntrState);
  assign sel_intr_enable = (word == WordIntrEnable);
  // Channel window is 0x100..0x17F: word[7:5] == 3'b010.
  assign in_chan_space   = (word[7:5] == 3'b010);
  assign chan_idx        = word[4:2];
  assign chan_reg        = word[1:0];

  assign be_mask = {{8{timer_be_i[3]}}, {8{timer_be_i[2]}},
                    {8{timer_be_i[1]}}, {8{timer_be_i[0]}}};

  // One-hot channel select; only implemented channels and registers hit.
  always_comb begin
    chan_sel = '0;
    for (int c = 0; c < int'(NumChannels); c++) begin
      chan_sel[c] = in_chan_space && (chan_idx == 3'(c)) && (chan_reg != 2'd3);
    end
  end

  assign dec_ok = sel_prescale | sel_intr_state | sel_intr_enable | (|chan_sel);
  // A write with a decode error never touches state.
  assign wr_en  = timer_req_i & timer_we_i & dec_ok;

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  logic [PrescalerWidth-1:0] prescale_q, prescale_d;
  logic [PrescalerWidth-1:0] pre_q, pre_d;
  logic                      tick;

  assign tick = (pre_q == prescale_q);

  // Prescaler reload register and free-running tick counter.
  always_comb begin
    prescale_d = prescale_q;
    pre_d      = tick ? '0 : pre_q + PrescalerWidth'(1);
    if (wr_en && sel_prescale) begin
      prescale_d = (prescale_q & ~be_mask[PrescalerWidth-1:0]) |
                   (timer_wdata_i[PrescalerWidth-1:0] & be_mask[PrescalerWidth-1:0]);
      // Restart the period so the new reload value takes effect cleanly.
      pre_d      = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Channels
  // -------------------------------------------------------------------------
  logic [NumChannels-1:0]  en_q, en_d;
  logic [NumChannels-1:0]  oneshot_q, oneshot_d;
  logic [CounterWidth-1:0] count_q   [NumChannels];
  logic [CounterWidth-1:0] count_d   [NumChannels];
  logic [CounterWidth-1:0] compare_q [NumChannels];
  logic [CounterWidth-1:0] compare_d [NumChannels];
  logic [NumChannels-1:0]  match;

  // Counter advance and match handling; a same-cycle software write to a
  // register overrides the hardware update of that register.
  always_comb begin
    for (int c = 0; c < int'(NumChannels); c++) begin
      match[c]     = tick && en_q[c] && (count_q[c] == compare_q[c]);
      en_d[c]      = en_q[c];
      oneshot_d[c] = oneshot_q[c];
      count_d[c]   = count_q[c];
      compare_d[c] = compare_q[c];

      if (match[c]) begin
        count_d[c] = '0;
        if (oneshot_q[c]) begin
          en_d[c] = 1'b0;
        end
      end else if (tick && en_q[c]) begin
        count_d[c] = count_q[c] + CounterWidth'(1);
      end

      if (wr_en && chan_sel[c]) begin
        case (chan_reg)
          ChanCtrl: begin
            if (timer_be_i[0]) begin
              en_d[c]      = timer_wdata_i[0];
              oneshot_d[c] = timer_wdata_i[1];
            end
          end
          ChanCount: begin
            count_d[c] = (count_q[c] & ~be_mask[CounterWidth-1:0]) |
                         (timer_wdata_i[CounterWidth-1:0] & be_mask[CounterWidth-1:0]);
          end
          ChanCompare: begin
            compare_d[c] = (compare_q[c] & ~be_mask[CounterWidth-1:0]) |
                           (timer_wdata_i[CounterWidth-1:0] & be_mask[CounterWidth-1:0]);
          end
          default: ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Interrupts
  // -------------------------------------------------------------------------
  logic [NumChannels-1:0] intr_state_q, intr_state_d;
  logic [NumChannels-1:0] intr_enable_q, intr_enable_d;
  logic [NumChannels-1:0] intr_clr;

  // W1C clear is applied before the hardware set so a coincident match wins.
  always_comb begin
    intr_clr      = '0;
    intr_enable_d = intr_enable_q;
    if (wr_en && sel_intr_state) begin
      intr_clr = timer_wdata_i[NumChannels-1:0] & be_mask[NumChannels-1:0];
    end
    if (wr_en && sel_intr_enable) begin
      intr_enable_d = (intr_enable_q & ~be_mask[NumChannels-1:0]) |
                      (timer_wdata_i[NumChannels-1:0] & be_mask[NumChannels-1:0]);
    end
    intr_state_d = (intr_state_q & ~intr_clr) | match;
  end

  // Driven straight from flops, so the lines cannot glitch.
  assign timer_chan_intr_o = intr_state_q & intr_enable_q;
  assign timer_intr_o      = |timer_chan_intr_o;

  // -------------------------------------------------------------------------
  // Bus response
  // -------------------------------------------------------------------------
  logic                 rvalid_q;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;

  // Read mux samples current register values, i.e. before same-cycle updates.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (timer_req_i) begin
      if (!dec_ok) begin
        err_d = 1'b1;
      end else if (!timer_we_i) begin
        if (sel_prescale) begin
          rdata_d[PrescalerWidth-1:0] = prescale_q;
        end
        if (sel_intr_state) begin
          rdata_d[NumChannels-1:0] = intr_state_q;
        end
        if (sel_intr_enable) begin
          rdata_d[NumChannels-1:0] = intr_enable_q;
        end
        for (int c = 0; c < int'(NumChannels); c++) begin
          if (chan_sel[c]) begin
            case (chan_reg)
              ChanCtrl:    rdata_d[1:0]              = {oneshot_q[c], en_q[c]};
              ChanCount:   rdata_d[CounterWidth-1:0] = count_q[c];
              ChanCompare: rdata_d[CounterWidth-1:0] = compare_q[c];
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign timer_rvalid_o = rvalid_q;
  assign timer_rdata_o  = rdata_q;
  assign timer_err_o    = err_q;

  // All state flops, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prescale_q    <= '0;
      pre_q         <= '0;
      intr_state_q  <= '0;
      intr_enable_q <= '0;
      en_q          <= '0;
      oneshot_q     <= '0;
      for (int c = 0; c < int'(NumChannels); c++) begin
        count_q[c]   <= '0;
        compare_q[c] <= '0;
      end
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      prescale_q    <= prescale_d;
      pre_q         <= pre_d;
      intr_state_q  <= intr_state_d;
      intr_enable_q <= intr_enable_d;
      en_q          <= en_d;
      oneshot_q     <= oneshot_d;
      for (int c = 0; c < int'(NumChannels); c++) begin
        count_q[c]   <= count_d[c];
        compare_q[c] <= compare_d[c];
      end
      rvalid_q      <= timer_req_i;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
    end
  end

  // Address bits outside [9:2] and data bits above the register widths are
  // intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{timer_addr_i, timer_wdata_i, be_mask};

endmodule

// File: tb/tb_simple_system_timer_mc.sv
// Self-checking bench for simple_system_timer_mc (2 channels, 8-bit counters).
// Bus responses go through a scoreboard queue; timer scenarios are
// hand-sequenced with cycle-exact expectations.

`timescale 1ns/1ps

module tb_simple_system_timer_mc;

  localparam int unsigned NumCh = 2;
  localparam int unsigned CntW  = 8;
  localparam int unsigned PreW  = 16;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             t_req = 1'b0;
  logic             t_we = 1'b0;
  logic [3:0]       t_be = 4'h0;
  logic [31:0]      t_addr = 32'h0;
  logic [31:0]      t_wdata = 32'h0;
  logic             timer_rvalid_o;
  logic [31:0]      timer_rdata_o;
  logic             timer_err_o;
  logic             timer_intr_o;
  logic [NumCh-1:0] timer_chan_intr_o;

  simple_system_timer_mc #(
    .NumChannels   (NumCh),
    .CounterWidth  (CntW),
    .PrescalerWidth(PreW),
    .DataWidth     (32),
    .AddressWidth  (32)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .timer_req_i      (t_req),
    .timer_we_i       (t_we),
    .timer_be_i       (t_be),
    .timer_addr_i     (t_addr),
    .timer_wdata_i    (t_wdata),
    .timer_rvalid_o   (timer_rvalid_o),
    .timer_rdata_o    (timer_rdata_o),
    .timer_err_o      (timer_err_o),
    .timer_intr_o     (timer_intr_o),
    .timer_chan_intr_o(timer_chan_intr_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int id    = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  logic exp_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the response seen after a clock edge against the scoreboard.
  task automatic monitor();
    exp_t e;
    if (exp_valid) begin
      chk("rvalid", 32'(timer_rvalid_o), 32'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got response with empty scoreboard");
      end else begin
        e = sb.pop_front();
        chk($sformatf("rdata#%0d", e.id), timer_rdata_o, e.rdata);
        chk($sformatf("err#%0d", e.id), 32'(timer_err_o), 32'(e.err));
      end
    end else begin
      chk("idle_rvalid", 32'(timer_rvalid_o), 32'd0);
      chk("idle_rdata", timer_rdata_o, 32'd0);
    end
    exp_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    monitor();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err);
    exp_t e;
    t_req   = 1'b1;
    t_we    = we;
    t_be    = be;
    t_addr  = addr;
    t_wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.id    = id;
    id++;
    sb.push_back(e);
    exp_valid = 1'b1;
    step();
    t_req   = 1'b0;
    t_we    = 1'b0;
    t_be    = 4'h0;
    t_addr  = 32'h0;
    t_wdata = 32'h0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(1'b1, 4'hF, addr, data, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    bus(1'b0, 4'hF, addr, 32'h0, exp, 1'b0);
  endtask

  task automatic add(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Register access vectors, applied back to back from reset state.
    add(0, 4'hF, 32'h000, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h004, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h008, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h100, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h104, 32'h0,        32'h0,    0);
    add(1, 4'h1, 32'h108, 32'hAABBCCDD, 32'h0,    0);
    add(0, 4'hF, 32'h108, 32'h0,        32'hDD,   0);
    add(1, 4'hF, 32'h108, 32'h00001234, 32'h0,    0);
    add(0, 4'hF, 32'h108, 32'h0,        32'h34,   0);
    add(0, 4'hF, 32'h120, 32'h0,        32'h0,    1);
    add(1, 4'hF, 32'h00C, 32'hFFFFFFFF, 32'h0,    1);
    add(1, 4'hF, 32'h128, 32'h00000055, 32'h0,    1);
    add(1, 4'hF, 32'h120, 32'h00000003, 32'h0,    1);
    add(0, 4'hF, 32'h100, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h108, 32'h0,        32'h34,   0);
    add(0, 4'hF, 32'h10C, 32'h0,        32'h0,    1);
    add(0, 4'hF, 32'h180, 32'h0,        32'h0,    1);
    add(0, 4'hF, 32'h00C, 32'h0,        32'h0,    1);
    add(1, 4'h3, 32'h000, 32'hFFFF1234, 32'h0,    0);
    add(0, 4'hF, 32'h000, 32'h0,        32'h1234, 0);
    add(1, 4'h2, 32'h000, 32'h00005600, 32'h0,    0);
    add(0, 4'hF, 32'h000, 32'h0,        32'h5634, 0);
    add(1, 4'hF, 32'h000, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h000, 32'h0,        32'h0,    0);
    add(1, 4'hF, 32'h008, 32'hFF,       32'h0,    0);
    add(0, 4'hF, 32'h008, 32'h0,        32'h3,    0);
    add(1, 4'hF, 32'h008, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h008, 32'h0,        32'h0,    0);
    add(1, 4'hF, 32'h110, 32'hFFFFFFFE, 32'h0,    0);
    add(0, 4'hF, 32'h110, 32'h0,        32'h2,    0);
    add(1, 4'h2, 32'h110, 32'hFFFFFFFF, 32'h0,    0);
    add(0, 4'hF, 32'h110, 32'h0,        32'h2,    0);
    add(1, 4'hF, 32'h110, 32'h0,        32'h0,    0);
    add(1, 4'hF, 32'h114, 32'h000001FE, 32'h0,    0);
    add(0, 4'hF, 32'h114, 32'h0,        32'hFE,   0);
    add(1, 4'hF, 32'h114, 32'h0,        32'h0,    0);
    add(1, 4'hF, 32'h108, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h400, 32'h0,        32'h0,    0);
    add(0, 4'hF, 32'h004, 32'h0,        32'h0,    0);

    // Reset.
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_rvalid", 32'(timer_rvalid_o), 32'd0);
    chk("rst_rdata", timer_rdata_o, 32'd0);
    chk("rst_err", 32'(timer_err_o), 32'd0);
    chk("rst_intr", 32'(timer_intr_o), 32'd0);
    chk("rst_chan_intr", 32'(timer_chan_intr_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    steps(2);

    // Table-driven register accesses.
    for (int i = 0; i < vecs.size(); i++) begin
      bus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
    end
    step();
    chk("sb_drain", 32'(sb.size()), 32'd0);

    // Periodic: PRESCALE=0, ch0 COMPARE=4 -> match every 5 cycles.
    wr(32'h108, 32'd4);
    wr(32'h008, 32'd1);
    wr(32'h100, 32'd1);
    steps(4);
    chk("per_before", 32'(timer_intr_o), 32'd0);
    step();
    chk("per_first", 32'(timer_intr_o), 32'd1);
    chk("per_first_ch", 32'(timer_chan_intr_o), 32'd1);
    wr(32'h004, 32'd1);
    chk("per_cleared", 32'(timer_intr_o), 32'd0);
    steps(3);
    chk("per_gap", 32'(timer_intr_o), 32'd0);
    step();
    chk("per_second", 32'(timer_intr_o), 32'd1);
    // W1C coincides with the next match: the set must win.
    steps(4);
    wr(32'h004, 32'd1);
    chk("w1c_collide", 32'(timer_intr_o), 32'd1);
    rd(32'h004, 32'd1);
    // COUNT write on a tick cycle: software value wins.
    wr(32'h104, 32'd7);
    rd(32'h104, 32'd7);
    wr(32'h100, 32'd0);
    rd(32'h104, 32'd9);
    rd(32'h104, 32'd9);
    wr(32'h004, 32'd3);
    rd(32'h004, 32'd0);
    chk("per_off", 32'(timer_intr_o), 32'd0);
    wr(32'h008, 32'd0);

    // Prescaler + one-shot: PRESCALE=3, ch1 COMPARE=2, enable aligned to pre=0.
    wr(32'h000, 32'd3);
    wr(32'h118, 32'd2);
    wr(32'h008, 32'd2);
    rd(32'h000, 32'd3);
    wr(32'h110, 32'd3);
    steps(11);
    chk("os_before", 32'(timer_chan_intr_o), 32'd0);
    step();
    chk("os_fire_ch", 32'(timer_chan_intr_o), 32'd2);
    chk("os_fire", 32'(timer_intr_o), 32'd1);
    rd(32'h110, 32'd2);
    rd(32'h114, 32'd0);
    wr(32'h004, 32'd2);
    steps(20);
    chk("os_no_second", 32'(timer_intr_o), 32'd0);
    rd(32'h114, 32'd0);
    rd(32'h110, 32'd2);

    // Wrap: 8-bit COUNT from 0xFE with COMPARE=0x10.
    wr(32'h000, 32'd0);
    wr(32'h108, 32'h10);
    wr(32'h104, 32'hFE);
    wr(32'h008, 32'd1);
    wr(32'h100, 32'd1);
    rd(32'h104, 32'hFE);
    rd(32'h104, 32'hFF);
    rd(32'h104, 32'h00);
    chk("wrap_no_intr", 32'(timer_intr_o), 32'd0);
    steps(15);
    chk("wrap_before", 32'(timer_intr_o), 32'd0);
    step();
    chk("wrap_fire", 32'(timer_intr_o), 32'd1);

    // Reset mid-run with an interrupt pending and a read outstanding.
    wr(32'h000, 32'd1);
    wr(32'h118, 32'd5);
    wr(32'h114, 32'd3);
    wr(32'h008, 32'd3);
    chk("pre_rst_intr", 32'(timer_intr_o), 32'd1);
    t_req  = 1'b1;
    t_we   = 1'b0;
    t_be   = 4'hF;
    t_addr = 32'h004;
    @(posedge clk_i);
    #1;
    chk("pre_rst_rvalid", 32'(timer_rvalid_o), 32'd1);
    t_req  = 1'b0;
    t_be   = 4'h0;
    t_addr = 32'h0;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(timer_rvalid_o), 32'd0);
    chk("mid_rst_rdata", timer_rdata_o, 32'd0);
    chk("mid_rst_err", 32'(timer_err_o), 32'd0);
    chk("mid_rst_intr", 32'(timer_intr_o), 32'd0);
    chk("mid_rst_chan", 32'(timer_chan_intr_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("rst_hold_rvalid", 32'(timer_rvalid_o), 32'd0);
    rst_ni = 1'b1;
    steps(3);
    rd(32'h000, 32'd0);
    rd(32'h004, 32'd0);
    rd(32'h008, 32'd0);
    rd(32'h100, 32'd0);
    rd(32'h104, 32'd0);
    rd(32'h108, 32'd0);
    rd(32'h110, 32'd0);
    rd(32'h114, 32'd0);
    rd(32'h118, 32'd0);
    steps(5);
    rd(32'h104, 32'd0);
    chk("post_rst_intr", 32'(timer_intr_o), 32'd0);
    chk("sb_final", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_system_timer_mc.md
# simple_system_timer_mc

Multi-channel, parametrised successor to the simple-system timer. It hangs off the simple-system bus as a single device in a 1 kB window. It provides `NumChannels` independent up-counters driven by one shared prescaler, each with a compare register and a periodic or one-shot mode. Interrupts are per-channel and maskable, and also OR-combined into one line for the core's `irq_timer_i`.

## Interface
- `NumChannels`, 4: number of channels, legal range 1..8.
- `CounterWidth`, 32: counter/compare width, legal range 8..32. Unimplemented upper bits read 0.
- `PrescalerWidth`, 16: prescaler width, legal range 1..32.
- `DataWidth`, 32: bus data width, fixed at 32.
- `AddressWidth`, 32: bus address width.

Ports:
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `timer_req_i` in 1: access request. Every request is accepted; there is no grant.
- `timer_we_i` in 1: 1 = write.
- `timer_be_i` in 4: byte enables.
- `timer_addr_i` in AddressWidth: byte address. Only `[9:2]` is decoded.
- `timer_wdata_i` in 32: write data.
- `timer_rvalid_o` out 1: response valid, for both reads and writes.
- `timer_rdata_o` out 32: read data, registered.
- `timer_err_o` out 1: error response, qualified by `timer_rvalid_o`.
- `timer_intr_o` out 1: OR of all enabled pending interrupts.
- `timer_chan_intr_o` out NumChannels: per-channel `INTR_STATE & INTR_ENABLE`.

## Operation
Register map (offsets from base):
- 0x000 `PRESCALE`: prescaler reload value, RW.
- 0x004 `INTR_STATE`: pending interrupts, write-1-to-clear.
- 0x008 `INTR_ENABLE`: interrupt mask, RW.
- 0x100 + 0x10·c, channel c:
  - +0x0 `CTRL`: bit0 `EN`, bit1 `ONESHOT`, other bits read 0.
  - +0x4 `COUNT`: RW.
  - +0x8 `COMPARE`: RW.

Prescaler:
- A free-running counter `pre` counts from 0 to `PRESCALE`.
- `tick` = (`pre` == `PRESCALE`). On `tick`, `pre` returns to 0.
- `PRESCALE` = 0 gives a tick every cycle. The tick period is `PRESCALE`+1 cycles.
- A write to `PRESCALE` clears `pre` to 0 in the same cycle.

Channel c, on a cycle with `tick` and `EN` = 1:
- If `COUNT` == `COMPARE`: set `INTR_STATE[c]` and load `COUNT` to 0. If `ONESHOT` = 1, also clear `EN`. The period is therefore `COMPARE`+1 ticks.
- Otherwise `COUNT` += 1, modulo 2^CounterWidth (wraps silently, no interrupt).
- A channel with `EN` = 0 holds `COUNT`.

Bus writes:
- Byte enables apply per byte to `PRESCALE`, `INTR_ENABLE`, `COUNT`, `COMPARE` and `CTRL`.
- For the W1C write to `INTR_STATE`, only bits in enabled bytes clear.
- Bits at or above `CounterWidth`, `PrescalerWidth` or `NumChannels` are ignored.

Decode errors:
- A decode error is any unmapped offset, or any channel c ≥ `NumChannels`.
- It gives `timer_err_o` = 1 and `timer_rdata_o` = 0. A write with a decode error has no effect.

Simultaneous events:
- Software write to `COUNT` or `CTRL` in the same cycle as a tick or match: the software write wins for that register. An interrupt from the match is still set.
- W1C of bit c in the same cycle as a hardware set of bit c: the set wins, so no interrupt is lost.
- Write to `COMPARE` in the same cycle as a tick: the compare uses the old value.

## Timing
- Reset values: all registers 0; `pre` = 0; every output 0.
- Reset is asynchronous, so assertion mid-operation clears state immediately. A pending `rvalid` is dropped.
- Response latency:
  - `timer_rvalid_o` asserts exactly 1 cycle after each `timer_req_i`.
  - Back-to-back requests give back-to-back responses.
  - `timer_rdata_o` and `timer_err_o` are valid only while `rvalid` is high; `timer_rdata_o` = 0 otherwise.
- Read values:
  - A read returns the register value from before any same-cycle update.
  - Register writes are visible to a read issued on the next cycle.
- Interrupt latency:
  - `INTR_STATE` sets at the clock edge ending the matching tick cycle.
  - `timer_chan_intr_o` and `timer_intr_o` follow combinationally from flops. They are glitch-free and rise 1 cycle after the match cycle.
  - They fall the cycle after a W1C clear or an `INTR_ENABLE` clear.

## Test plan
- **Periodic:** `PRESCALE`=0, ch0 `COMPARE`=4, `INTR_ENABLE`=1, `CTRL`=1 → `INTR_STATE[0]` sets every 5 cycles. After each W1C, `timer_intr_o` pulses again 5 cycles later.
- **Prescaler and one-shot:** `PRESCALE`=3, ch1 `COMPARE`=2, `CTRL`=3 → interrupt 12 cycles after enable. `CTRL` then reads 0x2, `COUNT` stays 0, and there is no second interrupt.
- **Wrap:** `CounterWidth`=8, `COUNT`=0xFE, `COMPARE`=0x10 → `COUNT` goes 0xFF, then 0x00, with no interrupt. The interrupt fires when `COUNT` reaches 0x10.
- **Bus errors:** with `NumChannels`=2, read 0x120 and write 0x00C → `rvalid`+`err` 1 cycle later, `rdata`=0, no state change. A `be`=4'b0001 write of 0xAABBCCDD to ch0 `COMPARE` reads back 0x000000DD.
- **Collisions:** W1C of bit0 in the same cycle as ch0 match → `INTR_STATE[0]` stays 1. A `COUNT` write of 7 on a tick cycle → reads 7.
- **Reset mid-run:** assert `rst_ni` low for 1 cycle with interrupts pending and a read outstanding → all outputs 0 immediately, no `rvalid`, all registers read 0 afterwards.
